// File: rtl/mor1kx_lsu_storebuf_pkg.sv
// mor1kx LSU shared definitions: access sizes, drain FSM states
// and the big-endian lane select / extend helpers.
package mor1kx_lsu_storebuf_pkg;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_DOUBLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_LOAD,
        ST_RESP,
        ST_ERR
    } lsu_state_t;

    function automatic logic lsu_misaligned(input logic [1:0] size,
                                            input logic [2:0] adr);
        logic m;
        unique case (size)
            SIZE_BYTE: m = 1'b0;
            SIZE_HALF: m = adr[0];
            SIZE_WORD: m = |adr[1:0];
            default:   m = |adr[2:0];
        endcase
        return m;
    endfunction

    // Lane 0 (lowest address) is the MSB; 32-bit buses use the top nibble.
    function automatic logic [7:0] lsu_bsel(input logic [1:0] size,
                                            input logic [2:0] off,
                                            input logic       wide);
        logic [7:0] b;
        unique case (size)
            SIZE_BYTE: b = 8'h80;
            SIZE_HALF: b = 8'hC0;
            SIZE_WORD: b = 8'hF0;
            default:   b = 8'hFF;
        endcase
        b = b >> off;
        return wide ? b : {4'h0, b[7:4]};
    endfunction

    function automatic logic [63:0] lsu_replicate(input logic [1:0]  size,
                                                  input logic [63:0] d);
        logic [63:0] r;
        unique case (size)
            SIZE_BYTE: r = {8{d[7:0]}};
            SIZE_HALF: r = {4{d[15:0]}};
            SIZE_WORD: r = {2{d[31:0]}};
            default:   r = d;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] lsu_extend(input logic [63:0] dat,
                                               input logic [2:0]  off,
                                               input logic [1:0]  size,
                                               input logic        zext,
                                               input logic        wide);
        logic [3:0]  lanes;
        logic [3:0]  nbytes;
        logic [6:0]  sh;
        logic [63:0] v;
        logic [63:0] r;
        lanes  = wide ? 4'd8 : 4'd4;
        nbytes = 4'd1 << size;
        sh     = {lanes - nbytes - {1'b0, off}, 3'b000};
        v      = dat >> sh;
        unique case (size)
            SIZE_BYTE: r = zext ? {56'd0, v[7:0]} : {{56{v[7]}}, v[7:0]};
            SIZE_HALF: r = zext ? {48'd0, v[15:0]} : {{48{v[15]}}, v[15:0]};
            SIZE_WORD: r = zext ? {32'd0, v[31:0]} : {{32{v[31]}}, v[31:0]};
            default:   r = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mor1kx_store_buffer.sv
// Posted-store FIFO holding {adr, lane data, bsel} entries.
// last flags a single remaining entry so the drain can stop without a bubble.
module mor1kx_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int DW    = 68
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          last
);

    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wp;
    logic [AW:0]   rp;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full)
                wp <= wp + ONE;
            if (pop && !empty)
                rp <= rp + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wp[AW-1:0]] <= din;
    end

    assign dout  = mem[rp[AW-1:0]];
    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign last  = ((wp - rp) == ONE);

endmodule

// File: rtl/mor1kx_lsu_storebuf.sv
// mor1kx load/store unit with posted store buffer; loads wait for the
// buffer to drain so memory ordering stays strict.
module mor1kx_lsu_storebuf
    import mor1kx_lsu_storebuf_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int STORE_BUF_DEPTH      = 4,
    parameter int STORE_BUF_AW         = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              lsu_go_i,
    input  logic                              lsu_load_i,
    input  logic                              lsu_store_i,
    input  logic [1:0]                        lsu_size_i,
    input  logic                              lsu_zext_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   lsu_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   lsu_dat_i,
    input  logic                              exception_taken_i,
    output logic                              lsu_ready_o,
    output logic                              lsu_valid_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   lsu_result_o,
    output logic                              lsu_except_align_o,
    output logic                              lsu_except_dbus_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   lsu_except_adr_o,
    output logic                              store_buf_empty_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_adr_o,
    output logic                              dbus_req_o,
    output logic                              dbus_we_o,
    output logic [OPTION_OPERAND_WIDTH/8-1:0] dbus_bsel_o,
    output logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_o,
    input  logic                              dbus_ack_i,
    input  logic                              dbus_err_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0]   dbus_dat_i
);

    localparam int W  = OPTION_OPERAND_WIDTH;
    localparam int BW = W / 8;
    localparam int DW = 2 * W + BW;
    localparam bit WIDE = (W == 64);

    lsu_state_t state_q, state_d;

    logic          legal, misal, go_ok, go_st, go_ld, go_mis;
    logic [2:0]    off, ld_off;
    logic [63:0]   st_dat64, ld_ext;
    logic [7:0]    st_bsel8, ld_bsel8;
    logic [DW-1:0] enq, head;
    logic [W-1:0]  head_adr, head_dat;
    logic [BW-1:0] head_bsel;
    logic          fifo_full, fifo_empty, fifo_last;
    logic          pop, flush;

    logic          valid_q, align_q, resp_err_q;
    logic          ld_pend_q, ld_kill_q, ld_zext_q;
    logic [1:0]    ld_size_q;
    logic [W-1:0]  ld_adr_q, exc_adr_q, result_q;

    assign off    = WIDE ? lsu_adr_i[2:0] : {1'b0, lsu_adr_i[1:0]};
    assign ld_off = WIDE ? ld_adr_q[2:0] : {1'b0, ld_adr_q[1:0]};
    assign legal  = (lsu_load_i ^ lsu_store_i) &&
                    !(lsu_size_i == SIZE_DOUBLE && !WIDE);
    assign misal  = lsu_misaligned(lsu_size_i, off);
    assign go_ok  = lsu_go_i && lsu_ready_o && legal;
    assign go_st  = go_ok && lsu_store_i && !misal;
    assign go_ld  = go_ok && lsu_load_i && !misal;
    assign go_mis = go_ok && misal;

    always_comb begin
        st_dat64 = lsu_replicate(lsu_size_i, 64'(lsu_dat_i));
        st_bsel8 = lsu_bsel(lsu_size_i, off, WIDE);
        ld_bsel8 = lsu_bsel(ld_size_q, ld_off, WIDE);
        ld_ext   = lsu_extend(64'(dbus_dat_i), ld_off, ld_size_q,
                              ld_zext_q, WIDE);
        enq      = {lsu_adr_i, st_dat64[W-1:0], st_bsel8[BW-1:0]};
    end

    assign head_adr  = head[DW-1 -: W];
    assign head_dat  = head[BW +: W];
    assign head_bsel = head[BW-1:0];

    assign pop   = (state_q == ST_DRAIN) && dbus_ack_i && !dbus_err_i;
    assign flush = (state_q == ST_DRAIN) && dbus_err_i;

    mor1kx_store_buffer #(
        .DEPTH (STORE_BUF_DEPTH),
        .AW    (STORE_BUF_AW),
        .DW    (DW)
    ) u_store_buffer (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (go_st),
        .pop   (pop),
        .din   (enq),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .last  (fifo_last)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty)
                    state_d = ST_DRAIN;
                else if (go_ld || (ld_pend_q && !exception_taken_i))
                    state_d = ST_LOAD;
            end
            ST_DRAIN: begin
                if (dbus_err_i)
                    state_d = ST_ERR;
                else if (dbus_ack_i && fifo_last && !go_st)
                    state_d = ST_IDLE;
            end
            ST_LOAD: begin
                if (dbus_ack_i || dbus_err_i)
                    state_d = (ld_kill_q || exception_taken_i) ?
                              ST_IDLE : ST_RESP;
            end
            ST_RESP:
                state_d = ST_IDLE;
            ST_ERR: begin
                if (exception_taken_i)
                    state_d = ST_IDLE;
            end
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dbus_req_o  = 1'b0;
        dbus_we_o   = 1'b0;
        dbus_adr_o  = '0;
        dbus_dat_o  = '0;
        dbus_bsel_o = '0;
        unique case (1'b1)
            state_q == ST_DRAIN: begin
                dbus_req_o  = 1'b1;
                dbus_we_o   = 1'b1;
                dbus_adr_o  = head_adr;
                dbus_dat_o  = head_dat;
                dbus_bsel_o = head_bsel;
            end
            state_q == ST_LOAD: begin
                dbus_req_o  = 1'b1;
                dbus_adr_o  = ld_adr_q;
                dbus_bsel_o = ld_bsel8[BW-1:0];
            end
            default: ;
        endcase
        lsu_valid_o       = valid_q || (state_q == ST_RESP);
        lsu_except_dbus_o = (state_q == ST_ERR) ||
                            ((state_q == ST_RESP) && resp_err_q);
        lsu_ready_o       = !fifo_full && !ld_pend_q &&
                            (state_q != ST_LOAD) && (state_q != ST_ERR);
        store_buf_empty_o = fifo_empty && (state_q != ST_DRAIN);
    end

    assign lsu_except_align_o = align_q;
    assign lsu_except_adr_o   = exc_adr_q;
    assign lsu_result_o       = result_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            align_q    <= 1'b0;
            resp_err_q <= 1'b0;
            ld_pend_q  <= 1'b0;
            ld_kill_q  <= 1'b0;
            ld_zext_q  <= 1'b0;
            ld_size_q  <= '0;
            ld_adr_q   <= '0;
            exc_adr_q  <= '0;
            result_q   <= '0;
        end else begin
            valid_q <= go_st || go_mis;
            align_q <= go_mis;
            if (go_mis)
                exc_adr_q <= lsu_adr_i;
            if (flush)
                exc_adr_q <= head_adr;
            if (state_q == ST_LOAD && dbus_err_i) begin
                exc_adr_q  <= ld_adr_q;
                resp_err_q <= 1'b1;
            end else if (state_q == ST_LOAD && dbus_ack_i) begin
                result_q   <= ld_ext[W-1:0];
                resp_err_q <= 1'b0;
            end
            if (go_ld) begin
                ld_adr_q  <= lsu_adr_i;
                ld_size_q <= lsu_size_i;
                ld_zext_q <= lsu_zext_i;
            end
            if (exception_taken_i)
                ld_pend_q <= 1'b0;
            else if (go_ld && state_d != ST_LOAD)
                ld_pend_q <= 1'b1;
            else if (state_d == ST_LOAD)
                ld_pend_q <= 1'b0;
            // A load already on the bus finishes but must not report back.
            ld_kill_q <= (state_d == ST_LOAD) &&
                         (ld_kill_q || exception_taken_i);
        end
    end

endmodule

// File: tb/tb_mor1kx_lsu_storebuf.sv
// Directed bench for mor1kx_lsu_storebuf: a 32-bit instance for ordering,
// buffering and exceptions, a 64-bit instance for wide loads.
module tb_mor1kx_lsu_storebuf;

    logic clk = 1'b0;
    logic rst;

    logic        go, ld, st, zext, exc, ack, err;
    logic [1:0]  size;
    logic [31:0] adr, dat, rdat;
    logic        ready, valid, e_align, e_dbus, sb_empty, req, we;
    logic [31:0] result, e_adr, b_adr, b_dat;
    logic [3:0]  bsel;

    logic        w_go, w_ld, w_ack;
    logic [1:0]  w_size;
    logic [63:0] w_adr, w_rdat;
    logic        w_ready, w_valid, w_e_align, w_e_dbus, w_sb_empty;
    logic        w_req, w_we;
    logic [63:0] w_result, w_e_adr, w_b_adr, w_b_dat;
    logic [7:0]  w_bsel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mor1kx_lsu_storebuf #(.OPTION_OPERAND_WIDTH(32)) u_dut32 (
        .clk                (clk),
        .rst                (rst),
        .lsu_go_i           (go),
        .lsu_load_i         (ld),
        .lsu_store_i        (st),
        .lsu_size_i         (size),
        .lsu_zext_i         (zext),
        .lsu_adr_i          (adr),
        .lsu_dat_i          (dat),
        .exception_taken_i  (exc),
        .lsu_ready_o        (ready),
        .lsu_valid_o        (valid),
        .lsu_result_o       (result),
        .lsu_except_align_o (e_align),
        .lsu_except_dbus_o  (e_dbus),
        .lsu_except_adr_o   (e_adr),
        .store_buf_empty_o  (sb_empty),
        .dbus_adr_o         (b_adr),
        .dbus_req_o         (req),
        .dbus_we_o          (we),
        .dbus_bsel_o        (bsel),
        .dbus_dat_o         (b_dat),
        .dbus_ack_i         (ack),
        .dbus_err_i         (err),
        .dbus_dat_i         (rdat)
    );

    mor1kx_lsu_storebuf #(.OPTION_OPERAND_WIDTH(64)) u_dut64 (
        .clk                (clk),
        .rst                (rst),
        .lsu_go_i           (w_go),
        .lsu_load_i         (w_ld),
        .lsu_store_i        (1'b0),
        .lsu_size_i         (w_size),
        .lsu_zext_i         (1'b0),
        .lsu_adr_i          (w_adr),
        .lsu_dat_i          (64'd0),
        .exception_taken_i  (1'b0),
        .lsu_ready_o        (w_ready),
        .lsu_valid_o        (w_valid),
        .lsu_result_o       (w_result),
        .lsu_except_align_o (w_e_align),
        .lsu_except_dbus_o  (w_e_dbus),
        .lsu_except_adr_o   (w_e_adr),
        .store_buf_empty_o  (w_sb_empty),
        .dbus_adr_o         (w_b_adr),
        .dbus_req_o         (w_req),
        .dbus_we_o          (w_we),
        .dbus_bsel_o        (w_bsel),
        .dbus_dat_o         (w_b_dat),
        .dbus_ack_i         (w_ack),
        .dbus_err_i         (1'b0),
        .dbus_dat_i         (w_rdat)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic l, input logic [1:0] sz,
                          input logic z, input logic [31:0] a,
                          input logic [31:0] d);
        go   = 1'b1;
        ld   = l;
        st   = !l;
        size = sz;
        zext = z;
        adr  = a;
        dat  = d;
    endtask

    task automatic idle();
        go = 1'b0;
        ld = 1'b0;
        st = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        size = 2'b00; zext = 1'b0; adr = '0; dat = '0;
        exc = 1'b0; ack = 1'b0; err = 1'b0; rdat = '0;
        w_go = 1'b0; w_ld = 1'b0; w_size = 2'b00; w_adr = '0;
        w_ack = 1'b0; w_rdat = '0;
        repeat (2) step();
        rst = 1'b0;

        chk("rst_ready", ready, 1);
        chk("rst_sb_empty", sb_empty, 1);
        chk("rst_valid", valid, 0);
        chk("rst_req", req, 0);
        chk("rst_w_ready", w_ready, 1);

        // sw 0xDEADBEEF @0x100 then lbz @0x101
        access(1'b0, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
        step();
        chk("st_valid", valid, 1);
        access(1'b1, 2'b00, 1'b1, 32'h101, 32'h0);
        chk("ld_go_ready", ready, 1);
        step();
        idle();
        chk("drain_req", req, 1);
        chk("drain_we", we, 1);
        chk("drain_adr", b_adr, 32'h100);
        chk("drain_dat", b_dat, 32'hDEADBEEF);
        chk("drain_bsel", bsel, 4'hF);
        chk("ld_wait_ready", ready, 0);
        step();
        chk("drain_hold", {req, b_adr}, {1'b1, 32'h100});
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("ld_no_early_req", req, 0);
        step();
        chk("ld_req", req, 1);
        chk("ld_we", we, 0);
        chk("ld_adr", b_adr, 32'h101);
        chk("ld_bsel", bsel, 4'b0100);
        rdat = 32'hDEADBEEF;
        ack  = 1'b1;
        step();
        ack  = 1'b0;
        chk("ld_valid", valid, 1);
        chk("ld_result", result, 32'h0000_00AD);
        step();
        chk("ld_valid_pulse", valid, 0);
        chk("ld_done_ready", ready, 1);

        // four sh with no ack fill the buffer
        for (int i = 0; i < 4; i++) begin
            access(1'b0, 2'b01, 1'b0, 32'(32'h200 + 2 * i),
                   32'(32'h1111 * (i + 1)));
            chk("fill_ready", ready, 1);
            step();
        end
        chk("full_ready", ready, 0);
        access(1'b0, 2'b01, 1'b0, 32'h208, 32'h5555);
        step();
        idle();
        chk("full_go_ignored", valid, 0);
        chk("head_bsel", bsel, 4'hC);
        chk("head_dat", b_dat, 32'h1111_1111);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", b_adr, 32'(32'h200 + 2 * i));
            ack = 1'b1;
            step();
            ack = 1'b0;
            if (i == 0) begin
                chk("ready_after_ack", ready, 1);
                chk("head2_bsel", bsel, 4'h3);
            end
        end
        chk("fill_drained", sb_empty, 1);
        chk("fill_no_5th", req, 0);

        // misaligned lw
        access(1'b1, 2'b10, 1'b0, 32'h102, 32'h0);
        step();
        idle();
        chk("mis_req", req, 0);
        chk("mis_valid", valid, 1);
        chk("mis_align", e_align, 1);
        chk("mis_adr", e_adr, 32'h102);
        step();
        chk("mis_pulse", e_align, 0);

        // second of three buffered stores errors
        for (int i = 0; i < 3; i++) begin
            access(1'b0, 2'b10, 1'b0, 32'(32'h300 + 4 * i), 32'(i + 1));
            step();
        end
        idle();
        chk("err_head", b_adr, 32'h300);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("err_second", b_adr, 32'h304);
        err = 1'b1;
        step();
        err = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("err_sticky", e_dbus, 1);
            chk("err_adr", e_adr, 32'h304);
            chk("err_no_third", req, 0);
            chk("err_ready", ready, 0);
            step();
        end
        exc = 1'b1;
        step();
        exc = 1'b0;
        chk("exc_ready", ready, 1);
        chk("exc_sb_empty", sb_empty, 1);
        chk("exc_cleared", e_dbus, 0);

        // exception while a load is on the bus
        access(1'b1, 2'b10, 1'b0, 32'h500, 32'h0);
        step();
        idle();
        chk("kill_req", req, 1);
        exc = 1'b1;
        step();
        exc = 1'b0;
        chk("kill_req_held", req, 1);
        ack = 1'b1;
        step();
        ack = 1'b0;
        chk("kill_no_valid", valid, 0);
        chk("kill_ready", ready, 1);

        // reset with a load on the bus
        access(1'b1, 2'b10, 1'b0, 32'h400, 32'h0);
        step();
        idle();
        chk("rst_ld_req", req, 1);
        rst = 1'b1;
        step();
        chk("rst_ld_req_drop", req, 0);
        chk("rst_ld_valid", valid, 0);
        chk("rst_ld_ready", ready, 1);
        rst = 1'b0;
        step();

        // 64-bit: ld @0x8, lhs @0xE
        w_go = 1'b1; w_ld = 1'b1; w_size = 2'b11; w_adr = 64'h8;
        step();
        w_go = 1'b0; w_ld = 1'b0;
        chk("w_ld_req", w_req, 1);
        chk("w_ld_bsel", w_bsel, 8'hFF);
        w_rdat = 64'h0123_4567_89AB_CDEF;
        w_ack  = 1'b1;
        step();
        w_ack  = 1'b0;
        chk("w_ld_valid", w_valid, 1);
        chk("w_ld_result", w_result, 64'h0123_4567_89AB_CDEF);
        step();
        w_go = 1'b1; w_ld = 1'b1; w_size = 2'b01; w_adr = 64'hE;
        step();
        w_go = 1'b0; w_ld = 1'b0;
        chk("w_lh_bsel", w_bsel, 8'h03);
        w_rdat = 64'h0000_0000_0000_8001;
        w_ack  = 1'b1;
        step();
        w_ack  = 1'b0;
        chk("w_lh_valid", w_valid, 1);
        chk("w_lh_result", w_result, 64'hFFFF_FFFF_FFFF_8001);
        step();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mor1kx_lsu_storebuf.md
Name: mor1kx_lsu_storebuf

Overview:
Parametrised load/store unit for the mor1kx pipelines, replacing the fixed 32-bit single-access LSU. It supports operand width 32 or 64, and big-endian byte/half/word/double accesses with generic sign/zero extension. Stores are posted into a STORE_BUF_DEPTH-entry FIFO and retire to the pipeline immediately. Loads issue only once the buffer has drained, which keeps memory ordering strict.

Parameters:
OPTION_OPERAND_WIDTH, 32, data/address width; 32 or 64 only
STORE_BUF_DEPTH, 4, store buffer entries; power of two, >=2
STORE_BUF_AW, 2, log2(STORE_BUF_DEPTH)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
lsu_go_i  in  1  start access; honoured only while lsu_ready_o=1
lsu_load_i  in  1  access is a load
lsu_store_i  in  1  access is a store
lsu_size_i  in  2  00 byte, 01 half, 10 word, 11 double (legal only when width=64)
lsu_zext_i  in  1  load zero-extends (1) or sign-extends (0)
lsu_adr_i  in  W  effective address
lsu_dat_i  in  W  store data, LSB-justified
exception_taken_i  in  1  pipeline entering exception handler
lsu_ready_o  out  1  can accept lsu_go_i
lsu_valid_o  out  1  one-cycle completion pulse
lsu_result_o  out  W  extended load data, valid with lsu_valid_o
lsu_except_align_o  out  1  alignment exception, pulses with lsu_valid_o
lsu_except_dbus_o  out  1  bus error (load: pulse; buffered store: sticky)
lsu_except_adr_o  out  W  faulting address
store_buf_empty_o  out  1  buffer empty and no store on bus (l.msync)
dbus_adr_o  out  W  bus address
dbus_req_o  out  1  bus request
dbus_we_o  out  1  write
dbus_bsel_o  out  W/8  byte enables, MSB = lowest address
dbus_dat_o  out  W  write data, replicated per lane
dbus_ack_i  in  1  transfer done
dbus_err_i  in  1  transfer error
dbus_dat_i  in  W  read data

Behaviour:
- Reset: all outputs 0 except lsu_ready_o=1 and store_buf_empty_o=1. FIFO pointers cleared. FSM goes to IDLE. Any in-flight bus transfer is abandoned.
- Alignment: half needs adr[0]=0; word needs adr[1:0]=0; double needs adr[2:0]=0. On misalignment: no bus access, nothing enqueued. Next cycle lsu_valid_o=lsu_except_align_o=1 and lsu_except_adr_o=adr.
- Store path:
  - An aligned store enqueues {adr, lane-replicated data, bsel} at the go edge.
  - lsu_valid_o pulses the next cycle.
  - lsu_ready_o=0 when the FIFO is full; a concurrent dequeue does not relieve full in that cycle.
- Drain: FSM states IDLE, DRAIN, LOAD, RESP, ERR.
  - IDLE->DRAIN when FIFO is non-empty.
  - In DRAIN, the head is presented with dbus_req_o=1, we=1. Request fields stay stable until ack/err.
  - On ack: pop the head; stay in DRAIN if more entries remain, else go to IDLE.
- Load:
  - An aligned load is latched at go. lsu_ready_o drops until completion.
  - The load waits until the FIFO is empty and no store is on the bus, then enters LOAD.
  - req is asserted the cycle after the drain condition is met (earliest: the cycle after go).
  - On ack: data is aligned by the latched adr and extended per size/zext, then registered. RESP pulses lsu_valid_o one cycle after ack.
- Load bus error: lsu_valid_o=lsu_except_dbus_o=1 one cycle after err, with lsu_except_adr_o=load adr.
- Store bus error:
  - FSM goes to ERR and the remaining FIFO entries are discarded.
  - lsu_except_dbus_o is held at 1 with lsu_except_adr_o=store adr.
  - lsu_ready_o=0 until exception_taken_i, which returns to IDLE.
- exception_taken_i:
  - Clears sticky/pending exceptions.
  - Drops a latched-but-unissued load.
  - A load already on the bus completes there, but its result is suppressed (no lsu_valid_o).
  - Committed store entries are kept and keep draining.
- ack and err in the same cycle: err wins.
- Illegal combinations (size 11 with W=32, load&store both 1): go is ignored; behaviour otherwise undefined.

Decomposition:
- Size encodings, FSM state localparams and the lane-select/extend function belong in shared mor1kx-defines.v entries.
- One sub-module: mor1kx_store_buffer, a synchronous FIFO of {adr, dat, bsel} with full/empty flags, STORE_BUF_DEPTH deep.

Test Plan:
- W=32: store word 0xDEADBEEF @0x100, then load byte zext @0x101 → the load's req appears only after the store ack; result 0x000000AD.
- Four sh stores with dbus_ack_i held low → lsu_ready_o=0 after the 4th; the 5th go is ignored. After one ack, ready returns to 1.
- W=64: load double @0x8 returns 0x0123456789ABCDEF → result unchanged, bsel 0xFF. Load half signed @0xE of data 0x...8001 → 0xFFFFFFFFFFFF8001.
- lw @0x102 → no req; next cycle valid=1, except_align=1, except_adr=0x102.
- Second of three buffered stores gets dbus_err_i → lsu_except_dbus_o held, except_adr=that store's adr, third store never issued. exception_taken_i → ready=1, store_buf_empty_o=1.
- rst asserted with a load on the bus → next cycle req=0, valid=0, ready=1.
